icache: RTL and testbench



---
 rtl/icache_pkg.sv | 13 +
 rtl/icache.sv | 158 +++++++++++++++
 tb/tb_icache.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared widths and FSM encodings for the direct-mapped instruction cache.
package icache_pkg;
  localparam int ADDRESS_WIDTH      = 32;
  localparam int INS_WIDTH          = 32;
  localparam int ICACHE_INDEX_BITS  = 6;
  localparam int ICACHE_OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    ICACHE_IDLE    = 2'd0,
    ICACHE_REFILL  = 2'd1,
    ICACHE_RESPOND = 2'd2
  } icache_state_e;
endpackage

// File: rtl/icache.sv
// Direct-mapped instruction cache: one-cycle hits, whole-line refill from the
// memory controller one word per transaction, rollback cancels the response.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = ICACHE_INDEX_BITS,
  parameter int OFFSET_BITS = ICACHE_OFFSET_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     if_req_valid,
  input  logic [ADDRESS_WIDTH-1:0] if_req_addr,
  output logic                     ic_ready,
  output logic                     ins_valid,
  output logic [INS_WIDTH-1:0]     ins_out,
  input  logic                     rollback_signal,
  output logic                     mc_req_valid,
  output logic [ADDRESS_WIDTH-1:0] mc_req_addr,
  input  logic                     mc_resp_valid,
  input  logic [INS_WIDTH-1:0]     mc_resp_data
);
  localparam int TAG_BITS = ADDRESS_WIDTH - 2 - OFFSET_BITS - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = LINES << OFFSET_BITS;

  icache_state_e r_state, w_state_nxt;
  logic [OFFSET_BITS-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                   r_drop, w_drop_nxt;
  logic                   r_ins_valid, w_ins_valid_nxt;
  logic [INS_WIDTH-1:0]   r_ins_out, w_ins_out_nxt;
  logic                   r_mc_req_valid, w_mc_req_valid_nxt;
  logic [ADDRESS_WIDTH-1:0] r_mc_req_addr, w_mc_req_addr_nxt;

  // Latched request fields for the line being refilled
  logic [TAG_BITS-1:0]    r_tag_l;
  logic [INDEX_BITS-1:0]  r_idx_l;
  logic [OFFSET_BITS-1:0] r_off_l;

  logic [LINES-1:0]     r_valid;
  logic [TAG_BITS-1:0]  r_tag  [LINES];
  logic [INS_WIDTH-1:0] r_data [WORDS];

  logic [TAG_BITS-1:0]    w_tag_req;
  logic [INDEX_BITS-1:0]  w_idx_req;
  logic [OFFSET_BITS-1:0] w_off_req;
  logic w_hit, w_accept, w_last;
  logic w_latch, w_inval, w_we, w_fill_done;

  assign w_tag_req = if_req_addr[ADDRESS_WIDTH-1 -: TAG_BITS];
  assign w_idx_req = if_req_addr[2+OFFSET_BITS +: INDEX_BITS];
  assign w_off_req = if_req_addr[2 +: OFFSET_BITS];
  assign w_hit     = r_valid[w_idx_req] && (r_tag[w_idx_req] == w_tag_req);
  assign w_accept  = (r_state == ICACHE_IDLE) && if_req_valid && !rollback_signal;
  assign w_last    = (r_cnt == {OFFSET_BITS{1'b1}});
  assign w_cnt_inc = r_cnt + 1'b1;

  assign ic_ready     = (r_state == ICACHE_IDLE);
  assign ins_valid    = r_ins_valid;
  assign ins_out      = r_ins_out;
  assign mc_req_valid = r_mc_req_valid;
  assign mc_req_addr  = r_mc_req_addr;

  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_drop_nxt         = r_drop;
    w_ins_valid_nxt    = 1'b0;
    w_ins_out_nxt      = r_ins_out;
    w_mc_req_valid_nxt = r_mc_req_valid;
    w_mc_req_addr_nxt  = r_mc_req_addr;
    w_latch            = 1'b0;
    w_inval            = 1'b0;
    w_we               = 1'b0;
    w_fill_done        = 1'b0;
    unique case (r_state)
      ICACHE_IDLE: begin
        if (w_accept) begin
          w_latch = 1'b1;
          if (w_hit) begin
            w_ins_valid_nxt = 1'b1;
            w_ins_out_nxt   = r_data[{w_idx_req, w_off_req}];
          end else begin
            w_inval            = 1'b1;
            w_state_nxt        = ICACHE_REFILL;
            w_cnt_nxt          = '0;
            w_mc_req_valid_nxt = 1'b1;
            w_mc_req_addr_nxt  = {w_tag_req, w_idx_req, {OFFSET_BITS{1'b0}}, 2'b00};
          end
        end
      end
      ICACHE_REFILL: begin
        if (rollback_signal) w_drop_nxt = 1'b1;
        if (mc_resp_valid) begin
          w_we = 1'b1;
          if (w_last) begin
            // Response is registered on the way into RESPOND; the requested
            // word may be the one arriving right now.
            w_fill_done        = 1'b1;
            w_state_nxt        = ICACHE_RESPOND;
            w_mc_req_valid_nxt = 1'b0;
            w_ins_valid_nxt    = !(r_drop || rollback_signal);
            w_ins_out_nxt      = (r_off_l == r_cnt) ? mc_resp_data
                                                    : r_data[{r_idx_l, r_off_l}];
          end else begin
            w_cnt_nxt         = w_cnt_inc;
            w_mc_req_addr_nxt = {r_tag_l, r_idx_l, w_cnt_inc, 2'b00};
          end
        end
      end
      ICACHE_RESPOND: begin
        w_drop_nxt  = 1'b0;
        w_state_nxt = ICACHE_IDLE;
      end
      default: w_state_nxt = ICACHE_IDLE;
    endcase
    if (rollback_signal) w_ins_valid_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ICACHE_IDLE;
      r_cnt          <= '0;
      r_drop         <= 1'b0;
      r_ins_valid    <= 1'b0;
      r_ins_out      <= '0;
      r_mc_req_valid <= 1'b0;
      r_mc_req_addr  <= '0;
      r_tag_l        <= '0;
      r_idx_l        <= '0;
      r_off_l        <= '0;
      r_valid        <= '0;
    end else if (rdy) begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_drop         <= w_drop_nxt;
      r_ins_valid    <= w_ins_valid_nxt;
      r_ins_out      <= w_ins_out_nxt;
      r_mc_req_valid <= w_mc_req_valid_nxt;
      r_mc_req_addr  <= w_mc_req_addr_nxt;
      if (w_latch) begin
        r_tag_l <= w_tag_req;
        r_idx_l <= w_idx_req;
        r_off_l <= w_off_req;
      end
      if (w_inval)     r_valid[w_idx_req] <= 1'b0;
      if (w_fill_done) r_valid[r_idx_l]   <= 1'b1;
    end
  end

  // Tag and data storage need no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (w_we)        r_data[{r_idx_l, r_cnt}] <= mc_resp_data;
      if (w_fill_done) r_tag[r_idx_l]           <= r_tag_l;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: misses, hits, eviction, rollback,
// rdy stalls and reset during refill.
module tb_icache;
  import icache_pkg::*;

  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic if_req_valid = 1'b0;
  logic [31:0] if_req_addr = '0;
  logic ic_ready, ins_valid, mc_req_valid;
  logic [31:0] ins_out, mc_req_addr;
  logic rollback_signal = 1'b0;
  logic mc_resp_valid = 1'b0;
  logic [31:0] mc_resp_data = '0;
  int checks = 0, errors = 0;

  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .ic_ready(ic_ready), .ins_valid(ins_valid), .ins_out(ins_out),
    .rollback_signal(rollback_signal),
    .mc_req_valid(mc_req_valid), .mc_req_addr(mc_req_addr),
    .mc_resp_valid(mc_resp_valid), .mc_resp_data(mc_resp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a[31:4] == 28'h10) return 32'hA0 + 32'(a[3:2]);
    return a ^ 32'hDEAD0000;
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic start_miss(input logic [31:0] a);
    if_req_valid = 1'b1; if_req_addr = a;
    @(negedge clk);
    if_req_valid = 1'b0;
    checks++;
    if (mc_req_valid !== 1'b1 || ic_ready !== 1'b0) begin
      errors++; $display("FAIL miss_start %h: mc_req_valid=%b ic_ready=%b, want 1/0", a, mc_req_valid, ic_ready);
    end
  endtask

  task automatic serve(input logic [31:0] line, input int lo, input int hi, input logic rb_last);
    for (int i = lo; i < hi; i++) begin
      checks++;
      if (mc_req_valid !== 1'b1 || mc_req_addr !== line + 32'(4*i)) begin
        errors++; $display("FAIL mc_req word %0d: valid=%b addr=%h, want 1 addr=%h", i, mc_req_valid, mc_req_addr, line + 32'(4*i));
      end
      mc_resp_valid = 1'b1; mc_resp_data = mem(line + 32'(4*i));
      if (rb_last && i == hi - 1) rollback_signal = 1'b1;
      @(negedge clk);
      mc_resp_valid = 1'b0; rollback_signal = 1'b0;
    end
  endtask

  task automatic hit(input logic [31:0] a);
    if_req_valid = 1'b1; if_req_addr = a;
    @(negedge clk);
    if_req_valid = 1'b0;
    checks++;
    if (ins_valid !== 1'b1 || ins_out !== mem(a) || mc_req_valid !== 1'b0) begin
      errors++; $display("FAIL hit %h: ins_valid=%b ins_out=%h mc_req_valid=%b, want 1 %h 0", a, ins_valid, ins_out, mc_req_valid, mem(a));
    end
    @(negedge clk);
  endtask

  task automatic expect_resp(input logic exp_v, input logic [31:0] a);
    checks++;
    if (ins_valid !== exp_v || (exp_v && ins_out !== mem(a))) begin
      errors++; $display("FAIL respond %h: ins_valid=%b ins_out=%h, want %b %h", a, ins_valid, ins_out, exp_v, mem(a));
    end
    @(negedge clk);
    checks++;
    if (ins_valid !== 1'b0 || ic_ready !== 1'b1) begin
      errors++; $display("FAIL post_respond %h: ins_valid=%b ic_ready=%b, want 0 1", a, ins_valid, ic_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ic_ready !== 1'b1 || ins_valid !== 1'b0 || ins_out !== 32'h0 ||
        mc_req_valid !== 1'b0 || mc_req_addr !== 32'h0) begin
      errors++; $display("FAIL reset: rdy=%b iv=%b io=%h mv=%b ma=%h, want 1 0 0 0 0", ic_ready, ins_valid, ins_out, mc_req_valid, mc_req_addr);
    end
  endtask

  task automatic test_cold_miss();
    start_miss(32'h104);
    serve(32'h100, 0, 4, 1'b0);
    expect_resp(1'b1, 32'h104);
  endtask

  task automatic test_hit();
    hit(32'h10C);
    hit(32'h100);
  endtask

  task automatic test_back_to_back();
    if_req_valid = 1'b1; if_req_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (ins_valid !== 1'b1 || ins_out !== 32'hA0) begin
      errors++; $display("FAIL b2b first: iv=%b io=%h, want 1 a0", ins_valid, ins_out);
    end
    if_req_addr = 32'h108;
    @(negedge clk);
    if_req_valid = 1'b0;
    checks++;
    if (ins_valid !== 1'b1 || ins_out !== 32'hA2) begin
      errors++; $display("FAIL b2b second: iv=%b io=%h, want 1 a2", ins_valid, ins_out);
    end
    @(negedge clk);
  endtask

  task automatic test_conflict();
    start_miss(32'h500);
    serve(32'h500, 0, 4, 1'b0);
    expect_resp(1'b1, 32'h500);
    start_miss(32'h100);
    serve(32'h100, 0, 4, 1'b0);
    expect_resp(1'b1, 32'h100);
  endtask

  task automatic test_rollback();
    // Rollback in IDLE drops the same-cycle request (0x700 would miss).
    if_req_valid = 1'b1; if_req_addr = 32'h700; rollback_signal = 1'b1;
    @(negedge clk);
    if_req_valid = 1'b0; rollback_signal = 1'b0;
    checks++;
    if (ic_ready !== 1'b1 || mc_req_valid !== 1'b0 || ins_valid !== 1'b0) begin
      errors++; $display("FAIL rb_idle: rdy=%b mv=%b iv=%b, want 1 0 0", ic_ready, mc_req_valid, ins_valid);
    end
    start_miss(32'h204);
    serve(32'h200, 0, 2, 1'b0);
    rollback_signal = 1'b1;
    @(negedge clk);
    rollback_signal = 1'b0;
    serve(32'h200, 2, 4, 1'b0);
    expect_resp(1'b0, 32'h204);
    hit(32'h208);
    // Rollback coincident with the final word
    start_miss(32'h304);
    serve(32'h300, 0, 4, 1'b1);
    expect_resp(1'b0, 32'h304);
    hit(32'h30C);
  endtask

  task automatic test_rdy_stall();
    start_miss(32'h400);
    serve(32'h400, 0, 1, 1'b0);
    rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mc_resp_valid = (c == 1 || c == 3); mc_resp_data = 32'hBAD0BAD0;
      @(negedge clk);
    end
    mc_resp_valid = 1'b0;
    checks++;
    if (mc_req_valid !== 1'b1 || mc_req_addr !== 32'h404 || ic_ready !== 1'b0) begin
      errors++; $display("FAIL stall: mv=%b ma=%h rdy=%b, want 1 404 0", mc_req_valid, mc_req_addr, ic_ready);
    end
    rdy = 1'b1;
    serve(32'h400, 1, 4, 1'b0);
    expect_resp(1'b1, 32'h400);
    hit(32'h404);
  endtask

  task automatic test_reset_mid_refill();
    start_miss(32'h600);
    serve(32'h600, 0, 2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ic_ready !== 1'b1 || mc_req_valid !== 1'b0 || ins_valid !== 1'b0) begin
      errors++; $display("FAIL rst_refill: rdy=%b mv=%b iv=%b, want 1 0 0", ic_ready, mc_req_valid, ins_valid);
    end
    start_miss(32'h600);
    serve(32'h600, 0, 4, 1'b0);
    expect_resp(1'b1, 32'h600);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_rollback();
    test_rdy_stall();
    test_reset_mid_refill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
